// File: rtl/binary_to_bcd_converter_param_if.sv
// Handshake and result bundle for binary_to_bcd_converter_param.
// The master drives requests and the converter (slave) returns packed BCD results.
interface binary_to_bcd_converter_param_if #(
    parameter int BINARY_DATA_SIZE = 8,
    parameter int BCD_DIGITS       = 3
);
    logic                          start_conversion;
    logic [BINARY_DATA_SIZE-1:0]   binary_data;
    logic                          ready;
    logic [4*BCD_DIGITS-1:0]       bcd_data;
    logic                          conversion_complete;
    logic                          overflow;
    logic                          sign;

    modport master (
        output start_conversion, binary_data,
        input  ready, bcd_data, conversion_complete, overflow, sign
    );

    modport slave (
        input  start_conversion, binary_data,
        output ready, bcd_data, conversion_complete, overflow, sign
    );
endinterface

// File: rtl/binary_to_bcd_converter_param.sv
// Multi-cycle shift-add-3 (double dabble) binary to packed BCD converter with overflow flag.
// Define BCD_SIGNED_INPUT_EN to treat binary_data as two's complement and report sign.
module binary_to_bcd_converter_param #(
    parameter int BINARY_DATA_SIZE = 8,
    parameter int BCD_DIGITS       = 3
) (
    input logic clk,
    input logic reset_n,
    binary_to_bcd_converter_param_if.slave bus
);
    localparam int N     = BINARY_DATA_SIZE;
    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int SH_W  = BCD_W + N;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N - 1);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_CONVERTING = 2'd1;
    localparam logic [1:0] ST_DONE       = 2'd2;

    logic [1:0]       state_q;
    logic [SH_W-1:0]  shift_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_acc_q;
    logic [BCD_W-1:0] bcd_q;
    logic             ovf_q;
    logic             complete_q;

    logic [N-1:0]     magnitude;
    logic [SH_W-1:0]  adjusted;
    logic [SH_W-1:0]  shifted;
    logic             carry_out;

`ifdef BCD_SIGNED_INPUT_EN
    logic negative;
    logic sign_acc_q;
    logic sign_q;

    // N-bit negate: -2^(N-1) wraps to 2^(N-1), which is its correct unsigned magnitude.
    assign negative  = bus.binary_data[N-1];
    assign magnitude = negative ? (~bus.binary_data + N'(1)) : bus.binary_data;
`else
    assign magnitude = bus.binary_data;
`endif

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        adjusted = shift_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (shift_q[N+4*d +: 4] > 4'd4) begin
                adjusted[N+4*d +: 4] = shift_q[N+4*d +: 4] + 4'd3;
            end
        end
        shifted   = {adjusted[SH_W-2:0], 1'b0};
        carry_out = adjusted[SH_W-1];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            ovf_acc_q  <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_conversion) begin
                        shift_q   <= {{BCD_W{1'b0}}, magnitude};
                        count_q   <= '0;
                        ovf_acc_q <= 1'b0;
                        state_q   <= ST_CONVERTING;
                    end
                end
                ST_CONVERTING: begin
                    shift_q   <= shifted;
                    count_q   <= count_q + CNT_W'(1);
                    ovf_acc_q <= ovf_acc_q | carry_out;
                    if (count_q == LAST_COUNT) begin
                        // Outputs change only here, so they never show a partial result.
                        bcd_q      <= shifted[SH_W-1 -: BCD_W];
                        ovf_q      <= ovf_acc_q | carry_out;
                        complete_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BCD_SIGNED_INPUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_acc_q <= 1'b0;
            sign_q     <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && bus.start_conversion) begin
                sign_acc_q <= negative;
            end
            if (state_q == ST_CONVERTING && count_q == LAST_COUNT) begin
                sign_q <= sign_acc_q;
            end
        end
    end

    assign bus.sign = sign_q;
`else
    assign bus.sign = 1'b0;
`endif

    assign bus.ready               = (state_q == ST_IDLE);
    assign bus.bcd_data            = bcd_q;
    assign bus.overflow            = ovf_q;
    assign bus.conversion_complete = complete_q;

endmodule

// File: tb/tb_binary_to_bcd_converter_param.sv
// Bench for binary_to_bcd_converter_param: one D=3 and one D=2 instance driven in lockstep,
// results checked against a vector table through a scoreboard queue.
module tb_binary_to_bcd_converter_param;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd3;
        logic [7:0]  bcd2;
        logic        ov2;
        logic        sgn;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] bin;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int pulses = 0;
    int pulse_cyc = 0;

    vec_t sb[$];
    vec_t vecs[10];

    binary_to_bcd_converter_param_if #(.BINARY_DATA_SIZE(8), .BCD_DIGITS(3)) if3 ();
    binary_to_bcd_converter_param_if #(.BINARY_DATA_SIZE(8), .BCD_DIGITS(2)) if2 ();

    assign if3.start_conversion = start;
    assign if3.binary_data      = bin;
    assign if2.start_conversion = start;
    assign if2.binary_data      = bin;

    binary_to_bcd_converter_param #(.BINARY_DATA_SIZE(8), .BCD_DIGITS(3)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if3)
    );

    binary_to_bcd_converter_param #(.BINARY_DATA_SIZE(8), .BCD_DIGITS(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic [11:0] d3,
                                input logic [7:0] d2, input logic o2, input logic s);
        vec_t v;
        v.bin  = b;
        v.bcd3 = d3;
        v.bcd2 = d2;
        v.ov2  = o2;
        v.sgn  = s;
        return v;
    endfunction

    // Scoreboard: every completion pulse pops the oldest expected result.
    always @(negedge clk) begin
        if (if3.conversion_complete) begin
            vec_t e;
            pulses++;
            pulse_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("bcd3", {20'd0, if3.bcd_data}, {20'd0, e.bcd3});
                check("ov3", {31'd0, if3.overflow}, 32'd0);
                check("sign", {31'd0, if3.sign}, {31'd0, e.sgn});
                check("complete2", {31'd0, if2.conversion_complete}, 32'd1);
                check("bcd2", {24'd0, if2.bcd_data}, {24'd0, e.bcd2});
                check("ov2", {31'd0, if2.overflow}, {31'd0, e.ov2});
            end
        end
    end

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if3.ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (pulses >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(name, pulses, target);
    endtask

    // One conversion with a single-cycle start pulse; checks latency, ready and hold.
    task automatic do_conv(input vec_t v);
        int acc;
        int p0;
        wait_ready();
        bin   = v.bin;
        start = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        acc   = cyc;
        start = 1'b0;
        p0    = pulses;
        wait_pulses(p0 + 1, 20, "pulse_timeout");
        check("latency", pulse_cyc - acc, 32'd8);
        check("ready_in_done", {31'd0, if3.ready}, 32'd0);
        @(negedge clk);
        check("ready_after", {31'd0, if3.ready}, 32'd1);
        check("complete_width", {31'd0, if3.conversion_complete}, 32'd0);
        check("bcd3_hold", {20'd0, if3.bcd_data}, {20'd0, v.bcd3});
    endtask

    initial begin
        vec_t a;
        vec_t b;
        vec_t v;
        int a1;
        int a2;
        int p0;
        bit found;

`ifdef BCD_SIGNED_INPUT_EN
        vecs[0] = mk(8'hFF, 12'h001, 8'h01, 1'b0, 1'b1);
        vecs[1] = mk(8'h2A, 12'h042, 8'h42, 1'b0, 1'b0);
        vecs[2] = mk(8'h00, 12'h000, 8'h00, 1'b0, 1'b0);
        vecs[3] = mk(8'h63, 12'h099, 8'h99, 1'b0, 1'b0);
        vecs[4] = mk(8'h80, 12'h128, 8'h28, 1'b1, 1'b1);
        vecs[5] = mk(8'h7F, 12'h127, 8'h27, 1'b1, 1'b0);
        vecs[6] = mk(8'h64, 12'h100, 8'h00, 1'b1, 1'b0);
        vecs[7] = mk(8'hF6, 12'h010, 8'h10, 1'b0, 1'b1);
        vecs[8] = mk(8'h01, 12'h001, 8'h01, 1'b0, 1'b0);
        vecs[9] = mk(8'hF0, 12'h016, 8'h16, 1'b0, 1'b1);
`else
        vecs[0] = mk(8'hFF, 12'h255, 8'h55, 1'b1, 1'b0);
        vecs[1] = mk(8'h2A, 12'h042, 8'h42, 1'b0, 1'b0);
        vecs[2] = mk(8'h00, 12'h000, 8'h00, 1'b0, 1'b0);
        vecs[3] = mk(8'h63, 12'h099, 8'h99, 1'b0, 1'b0);
        vecs[4] = mk(8'h80, 12'h128, 8'h28, 1'b1, 1'b0);
        vecs[5] = mk(8'h7F, 12'h127, 8'h27, 1'b1, 1'b0);
        vecs[6] = mk(8'h64, 12'h100, 8'h00, 1'b1, 1'b0);
        vecs[7] = mk(8'hF6, 12'h246, 8'h46, 1'b1, 1'b0);
        vecs[8] = mk(8'h01, 12'h001, 8'h01, 1'b0, 1'b0);
        vecs[9] = mk(8'hF0, 12'h240, 8'h40, 1'b1, 1'b0);
`endif

        // Reset state
        reset_n = 1'b0;
        start   = 1'b0;
        bin     = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, if3.ready}, 32'd1);
        check("rst_bcd3", {20'd0, if3.bcd_data}, 32'd0);
        check("rst_complete", {31'd0, if3.conversion_complete}, 32'd0);
        check("rst_ov3", {31'd0, if3.overflow}, 32'd0);
        check("rst_sign", {31'd0, if3.sign}, 32'd0);
        check("rst_bcd2", {24'd0, if2.bcd_data}, 32'd0);
        reset_n = 1'b1;

        // Table of single conversions
        for (int i = 0; i < 10; i++) begin
            do_conv(vecs[i]);
        end

        // Back-to-back with start held high: 00 then F0, accepted N+2 cycles apart
        a = vecs[2];
        b = vecs[9];
        wait_ready();
        bin   = a.bin;
        start = 1'b1;
        sb.push_back(a);
        a1 = cyc;
        p0 = pulses;
        @(posedge clk);
        @(negedge clk);
        bin = b.bin;
        sb.push_back(b);
        found = 1'b0;
        a2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if3.ready) begin
                a2 = cyc;
                found = 1'b1;
                break;
            end
        end
        check("b2b_found", {31'd0, found}, 32'd1);
        check("b2b_spacing", a2 - a1, 32'd10);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bin   = 8'h00;
        wait_pulses(p0 + 2, 30, "b2b_timeout");

        // Start pulse mid-conversion with different data is ignored
        v = vecs[1];
        wait_ready();
        bin   = v.bin;
        start = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        p0 = pulses;
        repeat (3) @(negedge clk);
        bin   = 8'h63;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = 8'h00;
        repeat (15) @(negedge clk);
        check("single_pulse", pulses - p0, 32'd1);
        check("ignore_ready", {31'd0, if3.ready}, 32'd1);

        // Reset after iteration 4 aborts the conversion
        wait_ready();
        bin   = 8'h63;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        p0 = pulses;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, if3.ready}, 32'd1);
        check("abort_bcd3", {20'd0, if3.bcd_data}, 32'd0);
        check("abort_complete", {31'd0, if3.conversion_complete}, 32'd0);
        check("abort_ov2", {31'd0, if2.overflow}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_pulse", pulses - p0, 32'd0);
        check("abort_bcd_kept0", {20'd0, if3.bcd_data}, 32'd0);

        // Fresh conversion after the abort
        do_conv(vecs[3]);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/binary_to_bcd_converter_param.md
Name: binary_to_bcd_converter_param

Overview:
- Multi-cycle, shift-add-3 (double dabble) binary-to-packed-BCD converter.
- Generalised over input width and BCD digit count.
- Adds a ready/start/complete handshake, asynchronous reset and an overflow flag for undersized digit counts.
- Sits between arithmetic cores and the seven-segment display controller; bcd_data feeds per-digit display inputs.

Parameters:
- BINARY_DATA_SIZE, 8, input width N in bits; legal range 1..32.
- BCD_DIGITS, 3, number of output BCD digits D; any value >= 1 is legal, undersizing is flagged via overflow.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start_conversion  input  1  request; sampled only when ready=1.
- binary_data  input  BINARY_DATA_SIZE  operand; captured on the accepting edge only.
- ready  output  1  high in IDLE only; decoded combinationally from the state register.
- bcd_data  output  4*BCD_DIGITS  packed BCD result, digit 0 in [3:0].
- conversion_complete  output  1  one-cycle registered pulse; result valid.
- overflow  output  1  result exceeded 10^D-1; valid with conversion_complete, held until the next completion.
- sign  output  1  input was negative (see Optional Feature); held with bcd_data.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, ready=1.
  - bcd_data=0, conversion_complete=0, overflow=0, sign=0.
  - Internal shift register and iteration counter cleared.
  - Reset mid-conversion aborts the conversion; no completion pulse follows.
- States: IDLE, CONVERTING, DONE.
- IDLE: on an edge with start_conversion=1:
  - Load shift register {D*4 zeros, magnitude(binary_data)}.
  - count=0; go to CONVERTING.
- CONVERTING, one iteration per clock:
  - Every BCD digit >4 gets +3 (4-bit add, no carry between digits).
  - Then the whole register shifts left by 1; count increments.
  - The bit shifted out of the BCD MSB is ORed into an internal overflow accumulator, cleared on load.
  - When count reaches N-1 on an iteration edge, that edge performs the final iteration and moves to DONE.
- DONE (exactly one cycle):
  - bcd_data, overflow and sign outputs were registered on the edge entering DONE.
  - conversion_complete=1 during this cycle only; next edge returns to IDLE.
- Latency:
  - Accept edge E0, iterations on edges E1..EN.
  - conversion_complete high between EN and EN+1; ready high again after EN+1.
  - For N=8 the pulse appears 8 clocks after the accept edge.
- start_conversion while ready=0 (CONVERTING or DONE) is ignored; no queuing.
- binary_data changes after E0 do not affect the result.
- bcd_data/overflow/sign hold their last result until the next DONE; they are never partially updated.
- Overflow: with insufficient D, bcd_data = value mod 10^D and overflow=1.
- Counter width: clog2(N+1) bits; no wrap within legal range.
- Start held continuously: a new conversion is accepted every N+2 cycles.

Optional Feature:
- Macro BCD_SIGNED_INPUT_EN.
- Defined:
  - binary_data is two's complement.
  - At load, magnitude = |binary_data| (N-bit unsigned, so -2^(N-1) converts correctly).
  - sign=1 for negative inputs, registered with bcd_data.
- Undefined:
  - binary_data is unsigned and is loaded as-is.
  - sign is constant 0.
  - No negation logic is synthesised.

Test Plan:
- N=8, D=3, binary_data=8'hFF, start 1 cycle → after 8 clocks conversion_complete pulses 1 cycle; bcd_data=12'h255, overflow=0; then ready=1.
- N=8, D=3, back-to-back: 8'h00 then 8'hF0, with start held high → bcd_data 12'h000 then 12'h240; accepts 10 clocks apart.
- Start pulse mid-conversion with a different binary_data → ignored; result matches the originally captured operand; exactly one completion pulse.
- N=8, D=2, binary_data=8'd255 → bcd_data=8'h55, overflow=1; next conversion of 8'd42 → 8'h42, overflow=0.
- Assert reset_n=0 at iteration 4, release → ready=1, outputs 0, no conversion_complete; a fresh conversion of 8'd99 → 12'h099.
- BCD_SIGNED_INPUT_EN defined, N=8, D=3: binary_data=8'h80 → bcd_data=12'h128, sign=1; 8'hF6 → 12'h010, sign=1; 8'h7F → 12'h127, sign=0.
